// File: rtl/isqrt_pipe_if.sv
// Purpose : operand/result bundle for the pipelined integer square root.
// Latency : none, wires only.
// Backpres: none; neither direction has a ready, so results cannot be stalled.
// Signals : x_vld/x carry the radicand in; y_vld/y carry floor(sqrt(x)) out;
//           r carries x - y*y and exists only when ISQRT_PIPE_REM_EN is defined.
// master = operand source / result sink, slave = the square-root block.
interface isqrt_pipe_if #(
    parameter int WIDTH = 32
);
    logic               x_vld;
    logic [WIDTH-1:0]   x;
    logic               y_vld;
    logic [WIDTH/2-1:0] y;
`ifdef ISQRT_PIPE_REM_EN
    logic [WIDTH/2:0]   r;

    modport master (output x_vld, output x, input y_vld, input y, input r);
    modport slave  (input x_vld, input x, output y_vld, output y, output r);
`else
    modport master (output x_vld, output x, input y_vld, input y);
    modport slave  (input x_vld, input x, output y_vld, output y);
`endif
endinterface

// File: rtl/isqrt_pipe.sv
// Purpose : fully pipelined restoring radix-4 integer square root, one root bit per stage.
// Latency : WIDTH/2 cycles from the x_vld sampling edge to y_vld.
// Backpres: none; accepts one operand per cycle and never stalls.
//
// Ports   : clk    - rising-edge clock for all state
//           rst_n  - asynchronous active-low reset; clears only the valid pipeline
//           bus    - isqrt_pipe_if slave: x_vld/x in, y_vld/y (and r) out
// Options : define ISQRT_PIPE_REM_EN to add the remainder output r = x - y*y.
// Params  : WIDTH - radicand width, even and >= 4; the root is WIDTH/2 bits.
module isqrt_pipe #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    isqrt_pipe_if.slave bus
);
    localparam int HW = WIDTH / 2;   // root width = number of stages
    localparam int RW = HW + 2;      // partial remainder / trial width

    // Valid shift register; w_vld_in[k] is the valid bit entering stage k.
    logic [HW-1:0]    r_vld;
    logic [HW-1:0]    w_vld_in;

    // Data entering each stage (stage 0 is fed straight from the bus).
    logic [HW-1:0]    w_root_in [HW];
    logic [RW-1:0]    w_rem_in  [HW];
    logic [WIDTH-1:0] w_rad_in  [HW];

    assign w_vld_in     = {r_vld[HW-2:0], bus.x_vld};
    assign w_root_in[0] = '0;
    assign w_rem_in[0]  = '0;
    assign w_rad_in[0]  = bus.x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_in;
        end
    end

    assign bus.y_vld = r_vld[HW-1];

    for (genvar k = 0; k < HW; k++) begin : g_stage
        logic [RW-1:0] w_sh;
        logic [RW-1:0] w_sub;
        logic [RW-1:0] w_diff;
        logic [RW-1:0] w_rem_nxt;
        logic [HW-1:0] w_root_nxt;
        logic          w_borrow;

        // Incoming remainder is at most 2*root < 2^(k+1) <= 2^HW, so its two
        // top bits are always zero and dropping them before the shift is lossless.
        assign w_sh  = {w_rem_in[k][RW-3:0], w_rad_in[k][WIDTH-1:WIDTH-2]};
        assign w_sub = {w_root_in[k], 2'b01};

        // Borrow out of the subtraction is the trial sign: set means trial < 0.
        assign {w_borrow, w_diff} = {1'b0, w_sh} - {1'b0, w_sub};

        assign w_rem_nxt  = w_borrow ? w_sh : w_diff;
        assign w_root_nxt = {w_root_in[k][HW-2:0], ~w_borrow};

        if (k < HW - 1) begin : g_mid
            logic [HW-1:0]    r_root;
            logic [RW-1:0]    r_rem;
            logic [WIDTH-1:0] r_rad;
            logic             w_unused_rem_msb;

            // Data registers load only behind a valid operand.
            always_ff @(posedge clk) begin
                if (w_vld_in[k]) begin
                    r_root <= w_root_nxt;
                    r_rem  <= w_rem_nxt;
                    r_rad  <= {w_rad_in[k][WIDTH-3:0], 2'b00};
                end
            end

            assign w_root_in[k+1] = r_root;
            assign w_rem_in[k+1]  = r_rem;
            assign w_rad_in[k+1]  = r_rad;

            assign w_unused_rem_msb = ^w_rem_in[k][RW-1:RW-2];
        end else begin : g_last
            logic [HW-1:0] r_y;
            logic          w_unused_last;

            // Output registers hold the last result while y_vld is low.
            always_ff @(posedge clk) begin
                if (w_vld_in[k]) begin
                    r_y <= w_root_nxt;
                end
            end

            assign bus.y = r_y;

`ifdef ISQRT_PIPE_REM_EN
            logic [HW:0] r_r;

            // Final remainder is <= 2*y, so it always fits in HW+1 bits.
            always_ff @(posedge clk) begin
                if (w_vld_in[k]) begin
                    r_r <= w_rem_nxt[HW:0];
                end
            end

            assign bus.r = r_r;

            assign w_unused_last = ^{w_rem_in[k][RW-1:RW-2], w_rad_in[k][WIDTH-3:0],
                                     w_rem_nxt[RW-1]};
`else
            assign w_unused_last = ^{w_rem_in[k][RW-1:RW-2], w_rad_in[k][WIDTH-3:0],
                                     w_rem_nxt};
`endif
        end
    end
endmodule

// File: tb/tb_isqrt_pipe.sv
// Scoreboarded bench for isqrt_pipe with WIDTH=32: directed operands push their
// hand-computed root/remainder and due cycle; a negedge monitor pops and compares.
module tb_isqrt_pipe;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    isqrt_pipe_if #(.WIDTH(WIDTH)) bus ();

    isqrt_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] y;
        logic [16:0] r;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    logic        have_last = 1'b0;
    logic [15:0] last_y;
    logic [16:0] last_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present an operand now (caller is already at posedge+1) and log its result.
    task automatic issue(input logic [31:0] xv, input logic [15:0] ey, input logic [16:0] er);
        exp_t e;
        bus.x_vld = 1'b1;
        bus.x     = xv;
        e.y   = ey;
        e.r   = er;
        e.due = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic send(input logic [31:0] xv, input logic [15:0] ey, input logic [16:0] er);
        @(posedge clk);
        #1;
        issue(xv, ey, er);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.x_vld = 1'b0;
        bus.x     = 32'hDEAD_BEEF;
    endtask

    // Monitor: every y_vld pops one expectation; y/r must hold between results.
    always @(negedge clk) begin
        if (bus.y_vld === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_y_vld: y_vld=1 with y=0x%0h at cycle %0d, expected no result",
                         bus.y, cyc);
            end else begin
                m_e = q.pop_front();
                check("root_y", 32'(bus.y), 32'(m_e.y));
                check("latency", cyc, m_e.due);
`ifdef ISQRT_PIPE_REM_EN
                check("rem_r", 32'(bus.r), 32'(m_e.r));
                last_r = bus.r;
`endif
                last_y    = bus.y;
                have_last = 1'b1;
            end
        end else if (have_last) begin
            check("y_hold", 32'(bus.y), 32'(last_y));
`ifdef ISQRT_PIPE_REM_EN
            check("r_hold", 32'(bus.r), 32'(last_r));
`endif
        end
    end

    // Back-to-back boundary/table vectors: x, floor(sqrt(x)), x - y*y.
    logic [31:0] tx [12] = '{32'd2, 32'd3, 32'd8, 32'd65535, 32'd999999, 32'd1000000,
                             32'h8000_0000, 32'h4000_0000, 32'h3FFF_FFFF, 32'hFFFE_0000,
                             32'hFFFE_0001, 32'd4};
    logic [15:0] ty [12] = '{16'd1, 16'd1, 16'd2, 16'd255, 16'd999, 16'd1000,
                             16'hB504, 16'h8000, 16'h7FFF, 16'hFFFE,
                             16'hFFFF, 16'd2};
    logic [16:0] tr [12] = '{17'd1, 17'd2, 17'd4, 17'd510, 17'd1998, 17'd0,
                             17'h157F0, 17'd0, 17'hFFFE, 17'h1FFFC,
                             17'd0, 17'd0};

    initial begin : main
        logic found;
        bus.x_vld = 1'b0;
        bus.x     = '0;

        // Reset state; x_vld high during reset must be ignored.
        repeat (2) @(posedge clk);
        #1;
        bus.x_vld = 1'b1;
        bus.x     = 32'd77;
        @(posedge clk);
        #1;
        check("reset_y_vld", 32'(bus.y_vld), 32'd0);

        // Release reset and present x=0 at the very first edge after release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'd0, 16'd0, 17'd0);
        idle();
        repeat (LAT + 4) idle();

        // Back-to-back boundary operands.
        send(32'd1, 16'd1, 17'd0);
        send(32'd15, 16'd3, 17'd6);
        send(32'd16, 16'd4, 17'd0);
        send(32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE);
        idle();
        repeat (LAT + 4) idle();

        // Gapped pattern 1,0,0,1,1,0,1.
        send(32'd100, 16'd10, 17'd0);
        idle();
        idle();
        send(32'd144, 16'd12, 17'd0);
        send(32'd99, 16'd9, 17'd18);
        idle();
        send(32'd65536, 16'd256, 17'd0);
        idle();
        repeat (LAT + 4) idle();

        // Table of further vectors, back to back.
        for (int i = 0; i < 12; i++) send(tx[i], ty[i], tr[i]);
        idle();
        repeat (LAT + 4) idle();

        // Reset with operands in flight: they must vanish.
        for (int i = 0; i < 8; i++) send(32'(i * i), 16'(i), 17'd0);
        idle();
        found = 1'b0;
        for (int t = 0; t < 4 * LAT && !found; t++) begin
            @(posedge clk);
            #1;
            if (bus.y_vld === 1'b1) found = 1'b1;
        end
        check("inflight_y_vld_seen", 32'(found), 32'd1);
        #1;
        rst_n     = 1'b0;
        q.delete();
        have_last = 1'b0;
        #1;
        check("async_clear_y_vld", 32'(bus.y_vld), 32'd0);
        bus.x_vld = 1'b1;
        bus.x     = 32'd12345;
        @(posedge clk);
        #1;
        check("in_reset_y_vld", 32'(bus.y_vld), 32'd0);
        bus.x_vld = 1'b0;
        rst_n     = 1'b1;
        repeat (LAT + 8) idle();

        send(32'd49, 16'd7, 17'd0);
        idle();
        repeat (LAT + 4) idle();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
